// File: rtl/bounce_gen_pkg.sv
// rtl/bounce_gen_pkg.sv - shared types, constants and helpers for the switch bounce emulator
package bounce_gen_pkg;

  localparam int LFSR_W  = 16;
  localparam int DWELL_W = 4;

  // Feedback taps at bits 15, 13, 12 and 10 of the shift register
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    GAP    = 2'd2,
    SETTLE = 2'd3
  } bg_state_e;

  // Feedback bit for a left-shifting Fibonacci LFSR
  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] q);
    return ^(q & LFSR_TAPS);
  endfunction

  // Segment dwell from the low LFSR nibble; a zero nibble would give an empty segment, so it becomes 1
  function automatic logic [DWELL_W-1:0] dwell_of(input logic [DWELL_W-1:0] low);
    return (low == '0) ? DWELL_W'(1) : low;
  endfunction

endpackage

// File: rtl/bounce_gen_lfsr16.sv
// rtl/bounce_gen_lfsr16.sv - free-running 16-bit Fibonacci LFSR with synchronous reload
module lfsr16
  import bounce_gen_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);

  // Shift left every cycle regardless of what the FSM is doing; reset reloads the seed
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED;
    end else begin
      q <= {q[LFSR_W-2:0], lfsr_fb(q)};
    end
  end

endmodule

// File: rtl/bounce_gen.sv
// rtl/bounce_gen.sv - mechanical switch emulator driving a seeded bounce burst onto sw_o
module bounce_gen
  import bounce_gen_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
  parameter int                SETTLE_CYC = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       level_i,
  input  logic [3:0] nbounce_i,
  output logic       sw_o,
  output logic       busy_o,
  output logic       done_o
);

  // Settle counter counts down to zero, so it is loaded with one less than the hold length
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

  bg_state_e          state;
  logic [LFSR_W-1:0]  lfsr_q;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] bounce_cnt;
  logic [7:0]         settle_cnt;
  logic               level_q;
  logic [DWELL_W-1:0] dwell_load;
  logic               lfsr_unused;

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk(clk),
    .rst(rst),
    .q  (lfsr_q)
  );

  // Dwell counter counts down to zero, so a segment of d cycles loads d-1
  assign dwell_load = dwell_of(lfsr_q[DWELL_W-1:0]) - DWELL_W'(1);

  // Upper LFSR bits only feed the shift register itself
  assign lfsr_unused = ^lfsr_q[LFSR_W-1:DWELL_W];

  // Sequence FSM: every output is set on the edge that enters the next segment
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sw_o       <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      dwell_cnt  <= '0;
      bounce_cnt <= '0;
      settle_cnt <= '0;
      level_q    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (level_i != sw_o) begin
              level_q <= level_i;
              busy_o  <= 1'b1;
              sw_o    <= level_i;
              if (nbounce_i != '0) begin
                bounce_cnt <= nbounce_i;
                dwell_cnt  <= dwell_load;
                state      <= PULSE;
              end else begin
                settle_cnt <= SETTLE_LOAD;
                state      <= SETTLE;
              end
            end else begin
              // Already at the requested level: acknowledge without a sequence
              done_o <= 1'b1;
            end
          end
        end

        PULSE: begin
          if (dwell_cnt == '0) begin
            sw_o      <= ~level_q;
            dwell_cnt <= dwell_load;
            state     <= GAP;
          end else begin
            dwell_cnt <= dwell_cnt - DWELL_W'(1);
          end
        end

        GAP: begin
          if (dwell_cnt == '0) begin
            sw_o       <= level_q;
            bounce_cnt <= bounce_cnt - DWELL_W'(1);
            if (bounce_cnt == DWELL_W'(1)) begin
              settle_cnt <= SETTLE_LOAD;
              state      <= SETTLE;
            end else begin
              dwell_cnt <= dwell_load;
              state     <= PULSE;
            end
          end else begin
            dwell_cnt <= dwell_cnt - DWELL_W'(1);
          end
        end

        SETTLE: begin
          if (settle_cnt == '0) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= IDLE;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bounce_gen.md
# bounce_gen

Synthesizable mechanical-switch emulator: on command, it drives a debounced-target level onto `sw_o` through a pseudo-random burst of bounce pulses, then settles. It is the transmit side of the `sw_i` interface consumed by the debouncer. It sits in FPGA self-test builds and in the bench in place of hand-written bounce tasks, giving reproducible, seed-controlled stimulus.

## Interface
- `SEED`, 16'hACE1, LFSR reset value; must be non-zero.
- `SETTLE_CYC`, 32, cycles `sw_o` is held stable at the target level before `done_o`; legal range 1..255.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_i`  in  1  one-cycle command strobe; sampled only in IDLE.
- `level_i`  in  1  target settled level; sampled with `start_i`.
- `nbounce_i`  in  4  number of bounce pulses (0..15); sampled with `start_i`.
- `sw_o`  out  1  emulated switch output.
- `busy_o`  out  1  high from the cycle after an accepted start until `done_o`.
- `done_o`  out  1  one-cycle pulse at sequence completion.

## Operation
- Reset values:
  - `sw_o`=0, `busy_o`=0, `done_o`=0.
  - State IDLE; LFSR=`SEED`; all counters 0.
- LFSR:
  - 16-bit Fibonacci, shift left, `fb = q[15]^q[13]^q[12]^q[10]`.
  - Advances every cycle out of reset, free-running, independent of state.
- Dwell value `d`:
  - Taken from `q[3:0]` at each segment start.
  - `d==0` is replaced by 1, so range is 1..15 cycles.
- States: IDLE, PULSE, GAP, SETTLE.
- IDLE:
  - `start_i`=1 with `level_i != sw_o` latches `level_i` as L and `nbounce_i` as N.
  - If N>0, go to PULSE; if N==0, go to SETTLE.
  - `start_i` with `level_i == sw_o` is a no-op: `done_o` pulses next cycle, `busy_o` stays 0, `sw_o` unchanged.
- PULSE: `sw_o`=L for `d` cycles, then go to GAP.
- GAP:
  - `sw_o`=~L for `d` cycles, using a freshly sampled `d`.
  - Decrement N; go to PULSE if N is still >0, else go to SETTLE.
- SETTLE:
  - `sw_o`=L for exactly `SETTLE_CYC` cycles.
  - Then `done_o`=1 for one cycle, `busy_o` drops in the same cycle, return to IDLE.
- Edge count on `sw_o` per accepted sequence: exactly 2N+1.
- `start_i` while not in IDLE is ignored, with no queuing.
- `rst` mid-sequence aborts immediately to reset values, including the LFSR reload.
- `sw_o`, `busy_o` and `done_o` are registered outputs with no combinational path from inputs.

## Timing
- Accepted `start_i` at edge k:
  - `busy_o`=1 from k+1.
  - First `sw_o` change at k+1, to L in both the N>0 and the N==0 case.
- Segment length is exact: a segment with dwell `d` holds `sw_o` for `d` full cycles.
- Total busy length = Σ(PULSE+GAP dwells) + `SETTLE_CYC`.
- `done_o` asserts in the cycle after the last SETTLE cycle.
- Earliest next accepted `start_i` is the cycle after `done_o`.
- A no-op start at edge k gives `done_o` at k+1.
- A given `SEED` and a given reset-to-start cycle offset yield bit-identical `sw_o` waveforms.

## Structure
- `bounce_gen_pkg`:
  - State enum `bg_state_e` (IDLE, PULSE, GAP, SETTLE).
  - LFSR tap constants and the `LFSR_W`=16 constant.
  - `DWELL_W`=4 constant.
- Sub-module `lfsr16`:
  - Ports `clk`, `rst`, `seed` parameter, `q[15:0]`.
  - Free-running, reloads on `rst`.
- Top holds the FSM, 4-bit dwell counter, 4-bit bounce counter, 8-bit settle counter, and the L latch.

## Test plan
- Reset: hold `rst` 2 cycles → `sw_o`=0, `busy_o`=0, `done_o`=0; LFSR=16'hACE1 at the first post-reset cycle.
- Clean edge: start with `level_i`=1, `nbounce_i`=0 → `sw_o` rises at k+1 with no other edges; `done_o` at k+1+32; `busy_o` high for exactly 32 cycles.
- Bounce burst: `level_i`=1, `nbounce_i`=5 → exactly 11 edges on `sw_o`; every segment length in 1..15 and matching the reference-model LFSR; final level 1; then `done_o`.
- Falling sequence: after the previous case, `level_i`=0, `nbounce_i`=15 → 31 edges, settles at 0; repeat with `level_i`=0 → no-op, `done_o` at k+1, no edge.
- Ignored start: pulse `start_i` every cycle while busy with `nbounce_i`=3 → only the first start is accepted; edge count is 7.
- Mid-sequence reset: assert `rst` during GAP of a `nbounce_i`=8 run → next cycle `sw_o`=0, `busy_o`=0, no `done_o`; a rerun produces a waveform identical to the first run.
